// File: rtl/shift_deserializer.sv
// shift_deserializer: serial-to-parallel converter with a double-buffered
// output word, a valid/ready handshake and a sticky overflow flag.
// Bit order (MSB or LSB first) is latched with the first bit of each word.
// Optional feature: define SHIFT_DESER_PARITY_EN to expect one even-parity
// bit after the N data bits; parity_err then reports the parity check.
// Without it, a word is exactly N bits and parity_err is tied to 0.
module shift_deserializer #(
   parameter int N = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         sin,
   input  logic         sin_valid,
   input  logic         msb_first,
   output logic [N-1:0] word_out,
   output logic         word_valid,
   input  logic         word_ready,
   output logic         overflow,
   output logic         busy,
   output logic         parity_err
);

   localparam int CW = $clog2(N + 1);

`ifdef SHIFT_DESER_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2} state_t;
`else
   typedef enum logic [0:0] {IDLE = 1'b0, DATA = 1'b1} state_t;
`endif

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_shift;
   logic          r_msb;

   logic [N-1:0]  r_word;
   logic          r_wvalid;
   logic          r_ovf;

   logic          w_msb;
   logic [N-1:0]  w_shifted;
   logic          w_last_data;
   logic          w_shift_en;
   logic          w_done;
   logic [N-1:0]  w_done_word;

   // The first bit of a word uses the live msb_first; later bits use the
   // order captured with that first bit.
   assign w_msb       = (r_state == IDLE) ? msb_first : r_msb;
   assign w_shifted   = w_msb ? {r_shift[N-2:0], sin} : {sin, r_shift[N-1:1]};
   assign w_last_data = (r_cnt == CW'(N - 1));

`ifdef SHIFT_DESER_PARITY_EN
   logic w_done_perr;
   logic r_perr;

   // The parity bit is not shifted in; data stays put while it is awaited.
   assign w_shift_en  = sin_valid && (r_state != PARITY);
   // The word is already complete in the shift register when parity arrives.
   assign w_done_word = r_shift;
   assign parity_err  = r_perr;
`else
   assign w_shift_en  = sin_valid;
   // The last data bit completes the word, so hand off the shifted value.
   assign w_done_word = w_shifted;
   assign parity_err  = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic and word-completion strobe.
   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
      w_done_perr = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            // N >= 2, so a first bit never completes a word on its own.
            if (sin_valid) w_state_nxt = DATA;
         end
         DATA: begin
            if (sin_valid && w_last_data) begin
`ifdef SHIFT_DESER_PARITY_EN
               w_state_nxt = PARITY;
`else
               w_state_nxt = IDLE;
               w_done      = 1'b1;
`endif
            end
         end
`ifdef SHIFT_DESER_PARITY_EN
         PARITY: begin
            if (sin_valid) begin
               w_state_nxt = IDLE;
               w_done      = 1'b1;
               // Even parity: XOR of data and parity bit is 0 for a good word.
               w_done_perr = (^r_shift) ^ sin;
            end
         end
`endif
         default: w_state_nxt = IDLE;
      endcase
   end

   // Shift register, bit counter and captured bit order; all hold on gaps.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_msb   <= 1'b0;
      end else if (w_shift_en) begin
         if (r_state == IDLE) r_msb <= msb_first;
         r_shift <= w_shifted;
         r_cnt   <= w_last_data ? '0 : r_cnt + CW'(1);
      end
   end

   // Output holding register: load on completion if the slot is free or
   // being drained this edge, otherwise drop the word and flag overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_word   <= '0;
         r_wvalid <= 1'b0;
         r_ovf    <= 1'b0;
      end else if (w_done) begin
         if (!r_wvalid || word_ready) begin
            r_word   <= w_done_word;
            r_wvalid <= 1'b1;
         end else begin
            r_ovf    <= 1'b1;
         end
      end else if (r_wvalid && word_ready) begin
         r_wvalid <= 1'b0;
      end
   end

`ifdef SHIFT_DESER_PARITY_EN
   // Parity status travels with the word it describes.
   always_ff @(posedge clk) begin
      if (reset)                             r_perr <= 1'b0;
      else if (w_done && (!r_wvalid || word_ready)) r_perr <= w_done_perr;
   end
`endif

   assign word_out   = r_word;
   assign word_valid = r_wvalid;
   assign overflow   = r_ovf;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a word-level model.
module tb_shift_deserializer;
   localparam int N = 6;
`ifdef SHIFT_DESER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int WL = N + PAR;

   logic clk = 1'b0, reset = 1'b1, sin = 1'b0, sin_valid = 1'b0;
   logic msb_first = 1'b0, word_ready = 1'b0;
   logic [N-1:0] word_out;
   logic word_valid, overflow, busy, parity_err;

   int n_cmp = 0, n_err = 0, n_hs = 0;
   bit started = 0;

   // Model state: bits of the word in arrival order plus the output slot.
   logic         m_buf [WL];
   int           m_cnt = 0;
   logic         m_msb = 1'b0;
   logic [N-1:0] m_word = '0;
   logic         m_valid = 1'b0, m_ovf = 1'b0, m_perr = 1'b0;

   shift_deserializer #(.N(N)) dut (
      .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid),
      .msb_first(msb_first), .word_out(word_out), .word_valid(word_valid),
      .word_ready(word_ready), .overflow(overflow), .busy(busy),
      .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_step();
      logic         done;
      logic [N-1:0] nw;
      logic         np;
      done = 1'b0; nw = '0; np = 1'b0;
      if (reset) begin
         m_cnt = 0; m_valid = 0; m_ovf = 0; m_word = '0; m_perr = 0;
         started = 1;
      end else begin
         if (sin_valid) begin
            if (m_cnt == 0) m_msb = msb_first;
            m_buf[m_cnt] = sin;
            m_cnt++;
            if (m_cnt == WL) begin
               done = 1'b1;
               for (int i = 0; i < N; i++)
                  if (m_msb) nw[N-1-i] = m_buf[i];
                  else       nw[i]     = m_buf[i];
               for (int i = 0; i < WL; i++) np = np ^ m_buf[i];
               if (PAR == 0) np = 1'b0;
               m_cnt = 0;
            end
         end
         if (done) begin
            if (!m_valid || word_ready) begin
               m_word = nw; m_perr = np; m_valid = 1'b1;
            end else begin
               m_ovf = 1'b1;
            end
         end else if (m_valid && word_ready) begin
            m_valid = 1'b0;
         end
      end
   endtask

   // Model advances on every rising edge with the inputs the DUT sees.
   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (started) begin
         chk("valid", word_valid, m_valid);
         chk("overflow", overflow, m_ovf);
         chk("busy", busy, m_cnt != 0);
         if (m_valid) begin
            chk("word", word_out, m_word);
            chk("parity_err", parity_err, m_perr);
         end
         if (!reset && word_valid && word_ready) n_hs++;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_bit(input logic b, input logic msb);
      sin_valid = 1'b1; sin = b; msb_first = msb;
      tick();
      sin_valid = 1'b0;
   endtask

   // bits[N-1] goes first; toggle flips msb_first on every other bit.
   task automatic send_word(input logic [N-1:0] bits, input logic msb,
                            input logic pbit, input int gap, input bit toggle);
      for (int i = 0; i < N; i++) begin
         send_bit(bits[N-1-i], (toggle && (i % 2 == 1)) ? !msb : msb);
         if (i < N - 1 || PAR != 0) repeat (gap) tick();
      end
      if (PAR != 0) send_bit(pbit, toggle ? !msb : msb);
   endtask

   task automatic consume();
      word_ready = 1'b1; tick(); word_ready = 1'b0;
   endtask

   initial begin
      int hs0;
      reset = 1'b1; tick(); tick(); reset = 1'b0;
      chk("rst_valid", word_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_word", word_out, 0);
      chk("rst_perr", parity_err, 0);

      // MSB first, consecutive bits
      send_word(6'b101100, 1'b1, 1'b1, 0, 0);
      chk("msb_word", word_out, 6'b101100);
      chk("msb_valid", word_valid, 1);
      chk("msb_model", m_word, 6'b101100);
`ifdef SHIFT_DESER_PARITY_EN
      chk("msb_perr", parity_err, 0);
`endif
      consume();
      chk("msb_drained", word_valid, 0);

      // LSB first with msb_first toggling mid-word
      send_word(6'b101100, 1'b0, 1'b1, 0, 1);
      chk("lsb_word", word_out, 6'b001101);
      chk("lsb_model", m_word, 6'b001101);
      consume();

      // 3-cycle gaps between bits
      send_word(6'b101100, 1'b1, 1'b1, 3, 0);
      chk("gap_word", word_out, 6'b101100);
      chk("gap_valid", word_valid, 1);
      consume();

      // Back-to-back words with the consumer always ready
      hs0 = n_hs;
      word_ready = 1'b1;
      send_word(6'b101100, 1'b1, 1'b1, 0, 0);
      send_word(6'b010101, 1'b1, 1'b1, 0, 0);
      chk("b2b_word2", word_out, 6'b010101);
      tick();
      word_ready = 1'b0;
      chk("b2b_count", n_hs - hs0, 2);
      chk("b2b_ovf", overflow, 0);

      // Overflow: second word dropped while the first is held
      send_word(6'b101100, 1'b1, 1'b1, 0, 0);
      send_word(6'b010101, 1'b1, 1'b1, 0, 0);
      chk("ovf_word", word_out, 6'b101100);
      chk("ovf_flag", overflow, 1);
      consume();
      chk("ovf_sticky1", overflow, 1);
      send_word(6'b111000, 1'b1, 1'b1, 0, 0);
      consume();
      chk("ovf_sticky2", overflow, 1);

      // Reset discards a partial word
      send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
      reset = 1'b1; tick(); reset = 1'b0;
      chk("rst2_busy", busy, 0);
      chk("rst2_ovf", overflow, 0);
      send_word(6'b111111, 1'b1, 1'b0, 0, 0);
      chk("rst2_word", word_out, 6'b111111);
      chk("rst2_model", m_word, 6'b111111);
      consume();

`ifdef SHIFT_DESER_PARITY_EN
      send_word(6'b101100, 1'b1, 1'b0, 0, 0);
      chk("par_bad", parity_err, 1);
      consume();
`endif

      // Randomized traffic, checked by the per-cycle compare process
      for (int c = 0; c < 3000; c++) begin
         reset      = ($urandom_range(0, 199) == 0);
         sin_valid  = ($urandom_range(0, 3) != 0);
         sin        = 1'($urandom);
         msb_first  = 1'($urandom);
         word_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      reset = 1'b0; sin_valid = 1'b0; word_ready = 1'b0;
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 The block SHALL have parameter N, default 6, meaning the data word width in bits (legal range N >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port sin, input, 1 bit: the serial data bit.
REQ-005 The block SHALL have port sin_valid, input, 1 bit: sin is sampled on an edge only when this is 1.
REQ-006 The block SHALL have port msb_first, input, 1 bit: bit order, 1 = MSB first, 0 = LSB first.
REQ-007 The block SHALL have port word_out, output, N bits: the assembled word.
REQ-008 The block SHALL have port word_valid, output, 1 bit: word_out holds an unconsumed word.
REQ-009 The block SHALL have port word_ready, input, 1 bit: the consumer accepts word_out this cycle.
REQ-010 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a completed word is dropped.
REQ-011 The block SHALL have port busy, output, 1 bit: 1 while a word is partially received.
REQ-012 The block SHALL have port parity_err, output, 1 bit: parity status of word_out, qualified by word_valid.

Function
REQ-013 The block SHALL use FSM states IDLE (0 bits held), DATA (1..N-1 bits held) and PARITY (N data bits held, parity bit awaited; reachable only with PARITY_EN).
REQ-014 The block SHALL capture the msb_first value at the edge that samples the first bit of a word, and SHALL ignore msb_first changes for the rest of that word.
REQ-015 For MSB first, the shift register SHALL shift left with sin entering bit 0, so the first bit ends at bit N-1.
REQ-016 For LSB first, the shift register SHALL shift right with sin entering bit N-1, so the first bit ends at bit 0.
REQ-017 Cycles with sin_valid=0 SHALL hold all shift, count and FSM state; gaps of any length are legal.
REQ-018 On the edge sampling the last bit of a word, the block SHALL transfer the word to the word_out holding register and set word_valid, visible the next cycle (latency 1 clock from the last bit).
REQ-019 After a word completes, the FSM SHALL return to IDLE, and the next bit SHALL be accepted on the immediately following cycle (double-buffered, no dead cycle).
REQ-020 A handshake SHALL occur when word_valid=1 and word_ready=1; word_valid SHALL clear on that edge unless a new word completes on the same edge.
REQ-021 If a word completes while word_valid=1 and word_ready=1 on the same edge, the new word SHALL load and word_valid SHALL stay 1.
REQ-022 If a word completes while word_valid=1 and word_ready=0, the new word SHALL be dropped, word_out/word_valid SHALL be unchanged, and overflow SHALL set.
REQ-023 overflow SHALL stay set until reset.
REQ-024 word_out SHALL be stable while word_valid=1 and no handshake occurs.
REQ-025 busy SHALL be 1 exactly when the FSM is in DATA or PARITY.

Reset
REQ-026 When reset=1 at a rising edge, the block SHALL clear the FSM to IDLE, the bit count and shift register to 0, word_out to 0, word_valid to 0, overflow to 0, busy to 0 and parity_err to 0.
REQ-027 Reset SHALL take priority over sin_valid and word_ready on the same edge, and any partial word SHALL be discarded.

Configuration
REQ-028 With macro SHIFT_DESER_PARITY_EN defined, each word SHALL be N data bits followed by one even-parity bit, and parity_err SHALL equal the XOR of the N data bits and the parity bit, loaded with word_out.
REQ-029 With SHIFT_DESER_PARITY_EN defined, the parity bit SHALL be the completing bit for REQ-018/021/022.
REQ-030 Without SHIFT_DESER_PARITY_EN, the PARITY state SHALL be absent, a word SHALL be N bits, and parity_err SHALL be tied to 0.

Verification
REQ-031 MSB-first test: N=6, msb_first=1, bits 1,0,1,1,0,0 on consecutive cycles SHALL give word_out=6'b101100 with word_valid=1 the cycle after the 6th bit.
REQ-032 LSB-first test: msb_first=0, the same bits SHALL give word_out=6'b001101; toggling msb_first mid-word SHALL leave the result unchanged.
REQ-033 Gap and back-to-back test: with sin_valid=0 gaps of 3 cycles between bits, the result SHALL be unchanged; two back-to-back words with word_ready=1 SHALL both be delivered and overflow SHALL stay 0.
REQ-034 Overflow test: word_ready=0 through two complete words SHALL keep the first word in word_out, set overflow=1, and keep overflow=1 after later handshakes.
REQ-035 Reset test: reset after 3 of 6 bits, then 6 new bits 111111, SHALL give word_out=6'b111111 with no residue, and busy SHALL be 0 in the cycle after reset.
REQ-036 Parity test (SHIFT_DESER_PARITY_EN): data 101100 with parity bit 1 SHALL give parity_err=0; with parity bit 0 it SHALL give parity_err=1.
